// File: rtl/bclk_eye_trainer.sv
// BCLK eye trainer: sweeps the IOD delay line, finds the widest stable-sample run
// and parks the delay line at that run's centre.
module bclk_eye_trainer #(
  parameter int NUM_TAPS      = 128,
  parameter int TAP_W         = $clog2(NUM_TAPS),
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_EYE       = 8
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic [7:0]       RX_DATA,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_CENTER,
  output logic [TAP_W:0]   EYE_WIDTH
);

  localparam int MAXC  = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_RETURN, S_PASS, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, run_start_q, best_start_q, center_q;
  logic [TAP_W:0]     run_len_q, best_len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         ref_q;
  logic               mis_q, park_q, phase_q, done_q, fail_q;

  logic               ld, mv, dir;
  logic               stable, last_tap, close_run, better;
  logic               settle_end, sample_end;
  logic [TAP_W:0]     run_inc, cand_len, best_len_nx;
  logic [TAP_W-1:0]   cand_start, best_start_nx, center_nx;

  // An eye needs a transition inside the word, so all-0 / all-1 never count as stable.
  assign stable     = !mis_q && (ref_q != 8'h00) && (ref_q != 8'hFF);
  assign last_tap   = (tap_q == TAP_W'(NUM_TAPS - 1));
  assign close_run  = !stable || last_tap;
  assign run_inc    = run_len_q + (TAP_W+1)'(1);
  assign cand_len   = stable ? run_inc : run_len_q;
  assign cand_start = (stable && run_len_q == '0) ? tap_q : run_start_q;
  assign better     = close_run && (cand_len > best_len_q);
  assign best_len_nx   = better ? cand_len   : best_len_q;
  assign best_start_nx = better ? cand_start : best_start_q;
  assign center_nx  = best_start_nx + TAP_W'((best_len_nx - (TAP_W+1)'(1)) >> 1);
  assign settle_end = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign sample_end = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    mv      = 1'b0;
    dir     = 1'b0;
    case (state_q)
      S_IDLE:   if (START) state_d = S_LOAD;
      S_LOAD: begin
        ld      = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (settle_end) state_d = park_q ? S_PASS : S_SAMPLE;
      S_SAMPLE: if (sample_end) state_d = S_EVAL;
      S_EVAL: begin
        if (!last_tap)                                  state_d = S_STEP;
        else if (best_len_nx < (TAP_W+1)'(MIN_EYE))     state_d = S_ERR;
        else                                            state_d = S_RETURN;
      end
      S_STEP: begin
        mv      = 1'b1;
        dir     = 1'b1;
        state_d = S_SETTLE;
      end
      S_RETURN: begin
        if (tap_q == center_q) state_d = S_SETTLE;
        else                   mv = !phase_q;
      end
      S_PASS:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Delay-line limit aborts immediately and suppresses any move this cycle.
    if (DELAY_LINE_OUT_OF_RANGE && !(state_q inside {S_IDLE, S_LOAD, S_PASS, S_ERR})) begin
      state_d = S_ERR;
      mv      = 1'b0;
      dir     = 1'b0;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tap_q <= '0; run_start_q <= '0; best_start_q <= '0; center_q <= '0;
      run_len_q <= '0; best_len_q <= '0; cnt_q <= '0; ref_q <= '0;
      mis_q <= 1'b0; park_q <= 1'b0; phase_q <= 1'b0; done_q <= 1'b0; fail_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          done_q <= 1'b0; fail_q <= 1'b0; park_q <= 1'b0;
          best_len_q <= '0; best_start_q <= '0; run_len_q <= '0; run_start_q <= '0;
          center_q <= '0; tap_q <= '0;
        end
        S_LOAD: begin
          tap_q <= '0;
          cnt_q <= '0;
        end
        S_SETTLE: cnt_q <= settle_end ? '0 : cnt_q + CNT_W'(1);
        S_SAMPLE: begin
          if (cnt_q == '0) begin
            ref_q <= RX_DATA;
            mis_q <= 1'b0;
          end else begin
            mis_q <= mis_q | (RX_DATA != ref_q);
          end
          cnt_q <= sample_end ? '0 : cnt_q + CNT_W'(1);
        end
        S_EVAL: begin
          run_len_q    <= stable ? run_inc : '0;
          run_start_q  <= cand_start;
          best_len_q   <= best_len_nx;
          best_start_q <= best_start_nx;
          phase_q      <= 1'b0;
          if (last_tap) center_q <= center_nx;
        end
        S_STEP: if (mv) tap_q <= tap_q + TAP_W'(1);
        S_RETURN: begin
          if (tap_q == center_q) park_q <= 1'b1;
          else                   phase_q <= ~phase_q;
          if (mv) tap_q <= tap_q - TAP_W'(1);
        end
        default: ;
      endcase
      if (state_d == S_PASS) done_q <= 1'b1;
      if (state_d == S_ERR)  fail_q <= 1'b1;
    end
  end

  assign DELAY_LINE_LOAD         = ld;
  assign EYE_MONITOR_CLEAR_FLAGS = ld;
  assign DELAY_LINE_MOVE         = mv;
  assign DELAY_LINE_DIRECTION    = dir;
  assign BUSY       = !(state_q inside {S_IDLE, S_PASS, S_ERR});
  assign DONE       = done_q;
  assign FAIL       = fail_q;
  assign TAP_CENTER = done_q ? center_q : '0;
  assign EYE_WIDTH  = best_len_q;

endmodule

// File: tb/tb_bclk_eye_trainer.sv
// Scoreboard bench for bclk_eye_trainer: behavioural IOD lane model, directed
// sweep scenarios, completion monitor comparing against queued expectations.
module tb_bclk_eye_trainer;
  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       START   = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       OOR     = 1'b0;
  logic       LOAD, MOVE, DIR, CLR, BUSY, DONE, FAIL;
  logic [6:0] TAP_CENTER;
  logic [7:0] EYE_WIDTH;

  bclk_eye_trainer dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .START(START), .RX_DATA(RX_DATA),
    .DELAY_LINE_OUT_OF_RANGE(OOR), .DELAY_LINE_LOAD(LOAD), .DELAY_LINE_MOVE(MOVE),
    .DELAY_LINE_DIRECTION(DIR), .EYE_MONITOR_CLEAR_FLAGS(CLR), .BUSY(BUSY),
    .DONE(DONE), .FAIL(FAIL), .TAP_CENTER(TAP_CENTER), .EYE_WIDTH(EYE_WIDTH)
  );

  initial forever #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int done; int fail; int center; int width; int tap; int dec; int loads;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           ncmp = 0, nmis = 0;
  int           mtap = 0, mode = 0, n_load = 0, n_inc = 0, n_dec = 0, n_viol = 0;
  logic [127:0] smap = '0;
  logic         tog = 1'b0, prev_move = 1'b0, df_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int a, input int b);
    logic [127:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  // IOD lane model: tracks tap from LOAD/MOVE, stable F0 inside map, toggling outside.
  initial forever begin
    @(negedge FAB_CLK);
    if (LOAD && MOVE) n_viol++;
    if (MOVE && prev_move) n_viol++;
    prev_move = MOVE;
    if (LOAD) begin
      mtap = 0; n_load++;
    end else if (MOVE) begin
      if (DIR) begin mtap++; n_inc++; end
      else     begin mtap--; n_dec++; end
    end
    tog = ~tog;
    if (mode == 1)                                     RX_DATA = 8'h00;
    else if (mtap >= 0 && mtap < 128 && smap[mtap])    RX_DATA = 8'hF0;
    else                                               RX_DATA = tog ? 8'hAA : 8'h55;
  end

  // Monitor: every rising DONE|FAIL consumes one expected result.
  initial forever begin
    @(negedge FAB_CLK); #1;
    if ((DONE | FAIL) && !df_prev) begin
      if (q.size() == 0) chk("unexpected_completion", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("done",       int'(DONE),       mon_e.done);
        chk("fail",       int'(FAIL),       mon_e.fail);
        chk("tap_center", int'(TAP_CENTER), mon_e.center);
        chk("eye_width",  int'(EYE_WIDTH),  mon_e.width);
        chk("final_tap",  mtap,             mon_e.tap);
        chk("dec_moves",  n_dec,            mon_e.dec);
        chk("load_count", n_load,           mon_e.loads);
      end
    end
    df_prev = DONE | FAIL;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge FAB_CLK); #1; end
  endtask

  task automatic pulse_start();
    n_load = 0; n_inc = 0; n_dec = 0;
    START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic run(input exp_t e);
    q.push_back(e);
    pulse_start();
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 8000 && q.size() != 0; c++) cyc(1);
    if (q.size() != 0) begin
      chk({nm, "_timeout"}, 0, 1);
      q.delete();
    end
    cyc(3);
  endtask

  task automatic wait_tap(input int t);
    int c;
    c = 0;
    while (mtap != t && c < 4000) begin cyc(1); c++; end
    if (mtap != t) chk("wait_tap_timeout", mtap, t);
  endtask

  initial begin
    cyc(3);
    chk("reset_outputs", int'({BUSY, DONE, FAIL, LOAD, MOVE, DIR, CLR, TAP_CENTER, EYE_WIDTH}), 0);
    ARST_N = 1'b1;
    cyc(2);

    smap = mk(40, 71);                       // single 32-tap eye
    run('{1, 0, 55, 32, 55, 72, 1});
    wait_done("s1");

    smap = mk(10, 29) | mk(60, 79);          // equal runs, first wins
    run('{1, 0, 19, 20, 19, 108, 1});
    wait_done("s2");

    mode = 1;                                // constant 00: no edge anywhere
    run('{0, 1, 0, 0, 127, 0, 1});
    wait_done("s3");
    mode = 0;

    smap = mk(120, 127);                     // run ends on the last tap
    run('{1, 0, 123, 8, 123, 4, 1});
    wait_done("s4");

    smap = mk(40, 71);                       // re-START while busy, then limit abort
    run('{0, 1, 0, 0, 50, 0, 1});
    wait_tap(20);
    START = 1'b1; cyc(1); START = 1'b0;
    wait_tap(50);
    cyc(2);
    OOR = 1'b1;
    cyc(1);
    chk("oor_fail_next_cycle", int'(FAIL), 1);
    chk("oor_busy_low",        int'(BUSY), 0);
    OOR = 1'b0;
    wait_done("s5");
    cyc(4);
    chk("oor_no_move_after", mtap, 50);
    chk("oor_inc_moves",     n_inc, 50);

    pulse_start();                           // reset mid-SAMPLE at tap 30
    wait_tap(30);
    cyc(11);
    #2 ARST_N = 1'b0;
    #1;
    chk("async_reset_outputs", int'({BUSY, DONE, FAIL, LOAD, MOVE, DIR, CLR, TAP_CENTER, EYE_WIDTH}), 0);
    cyc(2);
    ARST_N = 1'b1;
    cyc(2);
    chk("post_reset_idle", int'(BUSY), 0);
    run('{1, 0, 55, 32, 55, 72, 1});
    wait_done("s6");

    chk("protocol_violations", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
